traffic_phase_arbiter: RTL
==========================

# traffic_phase_arbiter

Demand-driven phase scheduler for a four-approach intersection. It shares the single green right-of-way among east, south, west and north requesters, driven by per-approach vehicle-sensor requests. Service is round-robin with minimum- and maximum-green enforcement, a yellow interval and an all-red clearance. It drives the same per-approach 3-bit light encoding as the fixed-cycle controller and replaces it where sensor inputs exist.

## Interface
- MIN_GREEN, 4: minimum green cycles once granted (≥1)
- MAX_GREEN, 8: green cap in cycles when another approach is waiting (≥MIN_GREEN)
- YELLOW_TIME, 3: yellow cycles (≥1)
- ALL_RED_TIME, 1: all-red clearance cycles (≥1)
- TW, 4: phase timer width; all timing parameters ≤ 2^TW
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req  input  4  vehicle request per approach; bit0 east, bit1 south, bit2 west, bit3 north; level-sensitive, sampled every edge
- east, south, west, north  output  3 each  light code: 1 GREEN, 2 YELLOW, 3 RED
- grant  output  4  one-hot of the approach currently green; 0 otherwise

## Operation
- Registered state: phase ∈ {IDLE, GREEN, YELLOW, ALL_RED}, cur[1:0] (last/current served approach), timer[TW-1:0].
- Outputs are a pure decode of phase/cur. There is no combinational path from req.
  - GREEN: light[cur]=1, others 3.
  - YELLOW: light[cur]=2, others 3.
  - IDLE/ALL_RED: all 3.
- timer clears to 0 on every phase entry and increments each cycle in phase. It saturates at 2^TW−1.
- Round-robin pick: the first set bit of req scanning cur+1, cur+2, cur+3, cur (mod 4). cur is therefore lowest priority.
- IDLE: if req≠0, then cur←pick and phase←GREEN. Otherwise stay in IDLE.
- GREEN: let other = |(req & ~onehot(cur)). Go to YELLOW when timer ≥ MIN_GREEN−1 and either:
  - !req[cur], or
  - other and timer ≥ MAX_GREEN−1.
  - Otherwise stay in GREEN. With no competing request and req[cur] held, green rests indefinitely.
- YELLOW: after timer == YELLOW_TIME−1, go to ALL_RED.
- ALL_RED: after timer == ALL_RED_TIME−1:
  - if req≠0, cur←pick and phase←GREEN; the same approach may be re-granted if it is the only requester;
  - else phase←IDLE, keeping cur.
- Reset: phase=IDLE, cur=3 (east wins the first pick), timer=0. All lights 3, grant=0.

## Timing
- Request in IDLE: req sampled high at edge k puts the green on outputs after edge k. The green is visible in the cycle following sampling.
- Phase durations:
  - Green lasts MIN_GREEN to MAX_GREEN cycles when contested, and ≥MIN_GREEN uncontested.
  - Yellow lasts exactly YELLOW_TIME cycles.
  - All-red lasts exactly ALL_RED_TIME cycles.
- Req deassertion before MIN_GREEN does not shorten green.
- Req changes during YELLOW or ALL_RED only affect the pick at the ALL_RED exit edge.
- Simultaneous requests are resolved solely by the round-robin pick. Two approaches are never green or yellow together.
- rst asserted in any phase: all lights RED from the next cycle. No yellow is inserted.

## Configuration
- TRAFFIC_PREEMPT_EN defined: adds input preempt (1) and input preempt_dir (2).
  - While preempt=1 in GREEN with cur≠preempt_dir: go to YELLOW at the next edge, ignoring MIN_GREEN.
  - In GREEN with cur==preempt_dir: hold green, ignoring MAX_GREEN.
  - At an ALL_RED exit or in IDLE: grant preempt_dir regardless of req and round-robin.
  - YELLOW and ALL_RED durations are never shortened.
- Not defined: the ports are absent and behaviour is exactly as above.

## Test plan
- Reset, req=0 for 20 cycles -> all lights 3 and grant=0 throughout.
- req=0001 pulsed one cycle from IDLE -> east=1 for 4 cycles, then east=2 for 3 cycles, then all 3 for 1 cycle, then IDLE.
- req=0001 held -> east green continuously for 30 cycles with no yellow.
- req=0101 held -> repeating sequence: east green 8 cycles, yellow 3, all-red 1, west green 8, yellow 3, all-red 1. South and north stay 3.
- req=1111 after reset -> greens served in order east, south, west, north, east. grant stays one-hot during green.
- rst during south yellow -> next cycle all 3. Then req=1111 grants east first.
- (TRAFFIC_PREEMPT_EN) preempt=1, preempt_dir=2 during east green at timer 1 -> east=2 the next cycle for 3 cycles, then all-red 1 cycle, then west green held while preempt=1.

Source files
------------

// File: rtl/traffic_phase_arbiter_if.sv
// traffic_phase_arbiter_if: request/light bundle between sensors, controller and lamp drivers; preempt pins exist only with TRAFFIC_PREEMPT_EN
interface traffic_phase_arbiter_if;
  logic [3:0] req;
  logic [2:0] east, south, west, north;
  logic [3:0] grant;
`ifdef TRAFFIC_PREEMPT_EN
  logic       preempt;
  logic [1:0] preempt_dir;
  modport master (output req, preempt, preempt_dir, input east, south, west, north, grant);
  modport slave  (input req, preempt, preempt_dir, output east, south, west, north, grant);
`else
  modport master (output req, input east, south, west, north, grant);
  modport slave  (input req, output east, south, west, north, grant);
`endif
endinterface

// File: rtl/traffic_phase_arbiter.sv
// traffic_phase_arbiter: round-robin sensor-driven phase scheduler with min/max green, yellow and all-red; TRAFFIC_PREEMPT_EN adds preemption
module traffic_phase_arbiter #(
  parameter int MIN_GREEN    = 4,
  parameter int MAX_GREEN    = 8,
  parameter int YELLOW_TIME  = 3,
  parameter int ALL_RED_TIME = 1,
  parameter int TW           = 4
) (
  input logic clk,
  input logic rst,
  traffic_phase_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, GREEN, YELLOW, ALL_RED} phase_t;
  phase_t phase, phase_n;
  logic [1:0] cur, cur_n, pick, c1, c2, c3, pdir;
  logic [TW-1:0] timer, timer_n;
  logic [3:0] on;
  logic [2:0] lt [4];
  logic pre, other, go, to_yellow;
`ifdef TRAFFIC_PREEMPT_EN
  assign pre  = bus.preempt;
  assign pdir = bus.preempt_dir;
`else
  assign pre  = 1'b0;
  assign pdir = 2'd0;
`endif
  assign c1 = cur + 2'd1;
  assign c2 = cur + 2'd2;
  assign c3 = cur + 2'd3;
  assign on = 4'b0001 << cur;
  assign pick = pre ? pdir : bus.req[c1] ? c1 : bus.req[c2] ? c2 : bus.req[c3] ? c3 : cur;
  assign go = pre | (|bus.req);
  assign other = |(bus.req & ~on);
  // preemption overrides both green limits: leave at once, or hold indefinitely
  assign to_yellow = pre ? (cur != pdir)
                   : (timer >= TW'(MIN_GREEN - 1)) && (!bus.req[cur] || (other && timer >= TW'(MAX_GREEN - 1)));
  always_comb begin
    phase_n = phase;
    cur_n   = cur;
    case (phase)
      IDLE:    if (go) begin phase_n = GREEN; cur_n = pick; end
      GREEN:   if (to_yellow) phase_n = YELLOW;
      YELLOW:  if (timer == TW'(YELLOW_TIME - 1)) phase_n = ALL_RED;
      ALL_RED: if (timer == TW'(ALL_RED_TIME - 1)) begin phase_n = go ? GREEN : IDLE; cur_n = go ? pick : cur; end
      default: phase_n = IDLE;
    endcase
    timer_n = (phase_n != phase) ? '0 : timer + TW'(~&timer);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= IDLE;
      cur   <= 2'd3;
      timer <= '0;
    end else begin
      phase <= phase_n;
      cur   <= cur_n;
      timer <= timer_n;
    end
  end
  for (genvar i = 0; i < 4; i++) begin : g_lt
    assign lt[i] = (phase == GREEN && on[i]) ? 3'd1 : (phase == YELLOW && on[i]) ? 3'd2 : 3'd3;
  end
  assign bus.east  = lt[0];
  assign bus.south = lt[1];
  assign bus.west  = lt[2];
  assign bus.north = lt[3];
  assign bus.grant = (phase == GREEN) ? on : 4'b0000;
endmodule
